uimm_bank_ctx: RTL and testbench
================================

Name: uimm_bank_ctx

Overview:
- Multi-context upper-immediate (UIMM) bank accumulator for the execute stage.
- LUI-class instructions deposit BANK_W-bit slices into numbered banks. Absolute-target consumers (SYSCALL, far jumps) read the concatenated banks plus their own low immediate.
- Generalises the single fixed 3-bank store:
  - parametric bank count and width;
  - CTX independent bank sets (e.g. user/kernel);
  - per-consumer required-bank mask;
  - optional clear-on-use;
  - strict/lenient completeness policy.
- Registered outputs feed stg_ex branch/trap logic.

Parameters:
- BANK_W, 12, width of one bank slice.
- NUM_BANKS, 3, number of upper banks per context.
- LOW_W, 12, width of the consumer's own low immediate.
- CTX, 2, number of independent bank contexts (≥1).
- CLEAR_ON_USE, 1, 1 = a consume invalidates that context's banks.
- STRICT, 1, 1 = missing required bank raises trap; 0 = missing banks zero-filled, no trap.
- Derived: OUT_W = NUM_BANKS*BANK_W+LOW_W (48 by default); BI_W = max(1,$clog2(NUM_BANKS)); CI_W = max(1,$clog2(CTX)).

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  synchronous active-high reset
- iw_stall  in  1  hold all state and outputs
- iw_flush  in  1  invalidate all contexts, cancel same-cycle ops
- iw_ctx  in  CI_W  context selected for this cycle's write/use
- iw_wr_en  in  1  bank write request
- iw_wr_bank  in  BI_W  bank index; bank NUM_BANKS-1 is most significant
- iw_wr_val  in  BANK_W  bank data
- iw_use_en  in  1  consume request
- iw_use_low  in  LOW_W  consumer low immediate
- iw_use_need  in  NUM_BANKS  banks required by this consumer
- ow_valid  out  1  one-cycle pulse, result registers updated
- ow_value  out  OUT_W  assembled target
- ow_trap  out  1  consume was incomplete (STRICT only)
- ow_missing  out  NUM_BANKS  required-but-invalid banks of last consume
- ow_bank_valid  out  NUM_BANKS  registered valid mask of context iw_ctx as of previous edge

Behaviour:
- Reset (iw_rst=1 at edge): all bank data and valid bits 0 in every context; ow_valid, ow_value, ow_trap, ow_missing, ow_bank_valid all 0. Reset overrides stall and flush.
- Stall (iw_stall=1, no reset): no state change. Write/use ignored, not queued. Outputs hold, including ow_valid (consumer samples only when unstalled).
- Flush (no reset, no stall): all valid bits in all contexts cleared. Data may be left unchanged. Same-cycle write and use discarded. ow_valid=0, ow_trap=0 next cycle.
- Write: at edge, bank[iw_ctx][iw_wr_bank] <= iw_wr_val and its valid bit is set. An out-of-range index (≥NUM_BANKS) is ignored.
- Use, latency 1: at edge, ow_valid<=1 and missing = iw_use_need & ~valid[iw_ctx], using pre-edge contents.
  - STRICT=1 and missing≠0:
    - ow_trap<=1;
    - ow_value = concatenation with missing banks forced 0 and the low field forced 0;
    - ow_missing<=missing.
  - Otherwise:
    - ow_trap<=0;
    - ow_value = {bank[NUM_BANKS-1] … bank[0], iw_use_low}, with invalid or non-required banks forced 0;
    - ow_missing<=missing (informational when STRICT=0).
- No use and no stall: ow_valid<=0; other result outputs hold.
- Clear-on-use (CLEAR_ON_USE=1): all valid bits of iw_ctx cleared after use, whether or not it trapped.
- Simultaneous write and use, same ctx:
  - use sees pre-write state (no forwarding);
  - clear-on-use applies first, then the write commits, so the written bank ends valid.
- Simultaneous write and use, different ctx is impossible (single iw_ctx).
- Contexts are fully independent. A write in ctx0 never alters ctx1 valid/data.
- Reset mid-sequence discards partial bank programming; a following use traps (STRICT).

Decomposition:
- Shared package/header (alongside src/sizes.vh): UIMM bank width and count defaults, trap cause code PSTATE_CAUSE_UIMM_STATE reuse, and a bank-index-to-bit-range macro.
- One sub-module, uimm_bank_set: a single context's NUM_BANKS data registers + valid mask with write/clear ports. It is instantiated CTX times via generate. The top handles context muxing, assembly, and output registers.

Test Plan (defaults unless noted):
1. ctx0 writes bank2=012, bank1=345, bank0=678; use need=111, low=9AB -> next cycle ow_valid=1, ow_value=0123456789AB, ow_trap=0, ow_missing=000; ow_bank_valid becomes 000 (clear-on-use).
2. After flush, write only bank0=AAA; use need=111, low=055 -> ow_trap=1, ow_missing=110, ow_value=000000AAA000.
3. STRICT=0 build: same stimulus as 2 -> ow_trap=0, ow_value=000000AAA055, ow_missing=110.
4. ctx1 writes all banks FFF; ctx0 use need=111 -> trap, ow_missing=111; then ctx1 use low=000 -> ow_value=FFFFFFFFF000, no trap.
5. Same-cycle use (need=001) and write bank0=123 in ctx0 with bank0 previously invalid -> trap, ow_missing=001; next cycle ow_bank_valid=001.
6. Stall asserted during a use for 3 cycles -> outputs and valid bits unchanged; drop stall with no request -> ow_valid=0; assert reset with stall=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/uimm_bank_ctx_pkg.sv
// Shared definitions for the multi-context upper-immediate bank accumulator.
`ifndef UIMM_BANK_RANGE
// Bit range of bank slice idx inside a flat vector of w-bit banks.
`define UIMM_BANK_RANGE(idx, w) ((idx)*(w)) +: (w)
`endif

package uimm_bank_ctx_pkg;
  localparam int UIMM_BANK_W_DEF    = 12;
  localparam int UIMM_NUM_BANKS_DEF = 3;
  localparam int UIMM_LOW_W_DEF     = 12;
  localparam int UIMM_CTX_DEF       = 2;

  // Trap cause reported upstream when a consumer finds its banks incomplete.
  localparam logic [4:0] PSTATE_CAUSE_UIMM_STATE = 5'd18;

  // Index width for n selectable items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uimm_bank_ctx_set.sv
// One context's bank data registers and valid mask.
// A clear and a write in the same cycle leave the written bank valid.
module uimm_bank_set
  import uimm_bank_ctx_pkg::*;
#(
  parameter int BANK_W    = UIMM_BANK_W_DEF,
  parameter int NUM_BANKS = UIMM_NUM_BANKS_DEF,
  localparam int BI_W     = idx_w(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [BI_W-1:0]             wr_bank,
  input  logic [BANK_W-1:0]           wr_val,
  output logic [NUM_BANKS*BANK_W-1:0] data,
  output logic [NUM_BANKS-1:0]        valid,
  output logic [NUM_BANKS-1:0]        valid_nxt
);
  logic [NUM_BANKS*BANK_W-1:0] data_reg;
  logic [NUM_BANKS-1:0]        valid_reg;
  logic [NUM_BANKS-1:0]        wr_hit;

  // Out-of-range bank indices match no bank and are silently dropped.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign wr_hit[gi]    = wr_en && (wr_bank == BI_W'(gi));
    assign valid_nxt[gi] = wr_hit[gi] | (valid_reg[gi] & ~clr);
  end

  // Bank storage: reset clears everything, writes load the addressed slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_nxt;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (wr_hit[b]) data_reg[`UIMM_BANK_RANGE(b, BANK_W)] <= wr_val;
      end
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
endmodule

// File: rtl/uimm_bank_ctx.sv
// Multi-context UIMM bank accumulator: LUI-class writes fill banks, consumers
// read the assembled absolute target one cycle later.
module uimm_bank_ctx
  import uimm_bank_ctx_pkg::*;
#(
  parameter int BANK_W       = UIMM_BANK_W_DEF,
  parameter int NUM_BANKS    = UIMM_NUM_BANKS_DEF,
  parameter int LOW_W        = UIMM_LOW_W_DEF,
  parameter int CTX          = UIMM_CTX_DEF,
  parameter int CLEAR_ON_USE = 1,
  parameter int STRICT       = 1,
  localparam int OUT_W       = NUM_BANKS*BANK_W + LOW_W,
  localparam int BI_W        = idx_w(NUM_BANKS),
  localparam int CI_W        = idx_w(CTX)
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic                 iw_stall,
  input  logic                 iw_flush,
  input  logic [CI_W-1:0]      iw_ctx,
  input  logic                 iw_wr_en,
  input  logic [BI_W-1:0]      iw_wr_bank,
  input  logic [BANK_W-1:0]    iw_wr_val,
  input  logic                 iw_use_en,
  input  logic [LOW_W-1:0]     iw_use_low,
  input  logic [NUM_BANKS-1:0] iw_use_need,
  output logic                 ow_valid,
  output logic [OUT_W-1:0]     ow_value,
  output logic                 ow_trap,
  output logic [NUM_BANKS-1:0] ow_missing,
  output logic [NUM_BANKS-1:0] ow_bank_valid
);
  logic [NUM_BANKS*BANK_W-1:0] set_data      [CTX];
  logic [NUM_BANKS-1:0]        set_valid     [CTX];
  logic [NUM_BANKS-1:0]        set_valid_nxt [CTX];
  logic [CTX-1:0]              set_clr;
  logic [CTX-1:0]              set_wr;

  logic [NUM_BANKS*BANK_W-1:0] sel_data;
  logic [NUM_BANKS-1:0]        sel_valid;
  logic [NUM_BANKS-1:0]        sel_valid_nxt;
  logic [NUM_BANKS*BANK_W-1:0] upper_masked;
  logic [NUM_BANKS-1:0]        missing;
  logic [NUM_BANKS-1:0]        keep;
  logic                        trap_now;
  logic [OUT_W-1:0]            value_now;

  logic                        valid_reg;
  logic [OUT_W-1:0]            value_reg;
  logic                        trap_reg;
  logic [NUM_BANKS-1:0]        missing_reg;
  logic [NUM_BANKS-1:0]        bank_valid_reg;

  // Stall freezes everything; flush cancels this cycle's write and use.
  logic act;
  logic use_ok;
  logic wr_ok;
  assign act    = !iw_stall;
  assign use_ok = act && !iw_flush && iw_use_en;
  assign wr_ok  = act && !iw_flush && iw_wr_en;

  for (genvar gi = 0; gi < CTX; gi++) begin : g_ctx
    logic ctx_hit;
    assign ctx_hit     = (iw_ctx == CI_W'(gi));
    assign set_clr[gi] = (act && iw_flush) || ((CLEAR_ON_USE != 0) && use_ok && ctx_hit);
    assign set_wr[gi]  = wr_ok && ctx_hit;

    uimm_bank_set #(
      .BANK_W    (BANK_W),
      .NUM_BANKS (NUM_BANKS)
    ) u_set (
      .clk       (iw_clk),
      .rst       (iw_rst),
      .clr       (set_clr[gi]),
      .wr_en     (set_wr[gi]),
      .wr_bank   (iw_wr_bank),
      .wr_val    (iw_wr_val),
      .data      (set_data[gi]),
      .valid     (set_valid[gi]),
      .valid_nxt (set_valid_nxt[gi])
    );
  end

  // Select the addressed context; an unpopulated index reads as empty.
  always_comb begin
    sel_data      = '0;
    sel_valid     = '0;
    sel_valid_nxt = '0;
    for (int c = 0; c < CTX; c++) begin
      if (iw_ctx == CI_W'(c)) begin
        sel_data      = set_data[c];
        sel_valid     = set_valid[c];
        sel_valid_nxt = set_valid_nxt[c];
      end
    end
  end

  assign missing  = iw_use_need & ~sel_valid;
  assign keep     = iw_use_need & sel_valid;
  assign trap_now = (STRICT != 0) && (|missing);

  // Only banks that are both required and valid contribute to the target.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_mask
    assign upper_masked[`UIMM_BANK_RANGE(gi, BANK_W)] =
      sel_data[`UIMM_BANK_RANGE(gi, BANK_W)] & {BANK_W{keep[gi]}};
  end

  assign value_now = {upper_masked, trap_now ? {LOW_W{1'b0}} : iw_use_low};

  // Result registers: a consume updates value/trap/missing, otherwise they hold.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      valid_reg      <= 1'b0;
      value_reg      <= '0;
      trap_reg       <= 1'b0;
      missing_reg    <= '0;
      bank_valid_reg <= '0;
    end else if (act) begin
      bank_valid_reg <= sel_valid_nxt;
      if (iw_flush) begin
        valid_reg <= 1'b0;
        trap_reg  <= 1'b0;
      end else begin
        valid_reg <= iw_use_en;
        if (iw_use_en) begin
          value_reg   <= value_now;
          trap_reg    <= trap_now;
          missing_reg <= missing;
        end
      end
    end
  end

  assign ow_valid      = valid_reg;
  assign ow_value      = value_reg;
  assign ow_trap       = trap_reg;
  assign ow_missing    = missing_reg;
  assign ow_bank_valid = bank_valid_reg;
endmodule

// File: tb/tb_uimm_bank_ctx.sv
// Bench for uimm_bank_ctx: strict and lenient builds side by side, directed
// scenarios followed by random traffic, checked against a bank-level model.
module tb_uimm_bank_ctx;
  logic        clk = 1'b0;
  logic        rst, stall, flush, ctx, wr_en, use_en;
  logic [1:0]  wr_bank;
  logic [11:0] wr_val, use_low;
  logic [2:0]  use_need;

  logic        s_valid, s_trap, l_valid, l_trap;
  logic [47:0] s_value, l_value;
  logic [2:0]  s_missing, s_bv, l_missing, l_bv;

  int vectors = 0;
  int miscompares = 0;

  // Model state: bank contents and valid flags per context, expected outputs.
  logic [11:0] bank_m [2][3];
  logic        vld_m  [2][3];
  logic        e_valid, e_trap_s, e_trap_l;
  logic [63:0] e_value_s, e_value_l;
  logic [2:0]  e_missing, e_bv;

  always #5 clk = ~clk;

  uimm_bank_ctx #(.STRICT(1)) u_strict (
    .iw_clk(clk), .iw_rst(rst), .iw_stall(stall), .iw_flush(flush), .iw_ctx(ctx),
    .iw_wr_en(wr_en), .iw_wr_bank(wr_bank), .iw_wr_val(wr_val),
    .iw_use_en(use_en), .iw_use_low(use_low), .iw_use_need(use_need),
    .ow_valid(s_valid), .ow_value(s_value), .ow_trap(s_trap),
    .ow_missing(s_missing), .ow_bank_valid(s_bv)
  );

  uimm_bank_ctx #(.STRICT(0)) u_lenient (
    .iw_clk(clk), .iw_rst(rst), .iw_stall(stall), .iw_flush(flush), .iw_ctx(ctx),
    .iw_wr_en(wr_en), .iw_wr_bank(wr_bank), .iw_wr_val(wr_val),
    .iw_use_en(use_en), .iw_use_low(use_low), .iw_use_need(use_need),
    .ow_valid(l_valid), .ow_value(l_value), .ow_trap(l_trap),
    .ow_missing(l_missing), .ow_bank_valid(l_bv)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] vmask(input int c);
    return {vld_m[c][2], vld_m[c][1], vld_m[c][0]};
  endfunction

  // Target = required&valid banks high-to-low, then low field (zero on trap).
  function automatic logic [63:0] assemble(input int c, input bit strict);
    logic [63:0] v;
    logic [2:0]  miss;
    v = 0;
    miss = use_need & ~vmask(c);
    for (int b = 2; b >= 0; b--)
      v = (v << 12) + ((use_need[b] && vld_m[c][b]) ? 64'(bank_m[c][b]) : 64'd0);
    v = (v << 12) + ((strict && miss != 0) ? 64'd0 : 64'(use_low));
    return v;
  endfunction

  // Apply the spec rules for one clock edge using the current inputs.
  task automatic model_edge();
    int c;
    c = int'(ctx);
    if (rst) begin
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < 3; b++) begin
          bank_m[i][b] = 0;
          vld_m[i][b]  = 0;
        end
      e_valid = 0; e_trap_s = 0; e_trap_l = 0;
      e_value_s = 0; e_value_l = 0; e_missing = 0; e_bv = 0;
    end else if (stall) begin
      // everything holds
    end else if (flush) begin
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < 3; b++) vld_m[i][b] = 0;
      e_valid = 0; e_trap_s = 0; e_trap_l = 0; e_bv = 0;
    end else begin
      e_valid = use_en;
      if (use_en) begin
        e_missing = use_need & ~vmask(c);
        e_trap_s  = (e_missing != 0);
        e_trap_l  = 0;
        e_value_s = assemble(c, 1);
        e_value_l = assemble(c, 0);
        for (int b = 0; b < 3; b++) vld_m[c][b] = 0;
      end
      if (wr_en && wr_bank < 3) begin
        bank_m[c][wr_bank] = wr_val;
        vld_m[c][wr_bank]  = 1;
      end
      e_bv = vmask(c);
    end
  endtask

  task automatic compare_all();
    check("s_valid", 64'(s_valid), 64'(e_valid));
    check("s_value", 64'(s_value), e_value_s);
    check("s_trap", 64'(s_trap), 64'(e_trap_s));
    check("s_missing", 64'(s_missing), 64'(e_missing));
    check("s_bank_valid", 64'(s_bv), 64'(e_bv));
    check("l_valid", 64'(l_valid), 64'(e_valid));
    check("l_value", 64'(l_value), e_value_l);
    check("l_trap", 64'(l_trap), 64'(e_trap_l));
    check("l_missing", 64'(l_missing), 64'(e_missing));
    check("l_bank_valid", 64'(l_bv), 64'(e_bv));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; wr_en = 0; use_en = 0;
    wr_bank = 0; wr_val = 0; use_low = 0; use_need = 0;
  endtask

  task automatic wr(input logic c, input logic [1:0] b, input logic [11:0] v);
    idle(); ctx = c; wr_en = 1; wr_bank = b; wr_val = v;
  endtask

  task automatic use_op(input logic c, input logic [2:0] need, input logic [11:0] low);
    idle(); ctx = c; use_en = 1; use_need = need; use_low = low;
  endtask

  initial begin
    idle(); ctx = 0; rst = 1;
    tick();
    check("reset_value", 64'(s_value), 64'd0);
    check("reset_bank_valid", 64'(s_bv), 64'd0);

    // Full program then consume in ctx0.
    wr(0, 2, 12'h012); tick();
    wr(0, 1, 12'h345); tick();
    wr(0, 0, 12'h678); tick();
    use_op(0, 3'b111, 12'h9AB); tick();
    check("t1_value", 64'(s_value), 64'h0123456789AB);
    check("t1_trap", 64'(s_trap), 64'd0);
    check("t1_cleared", 64'(s_bv), 64'd0);

    // Partial program after flush: strict traps, lenient zero-fills.
    idle(); flush = 1; tick();
    wr(0, 0, 12'hAAA); tick();
    use_op(0, 3'b111, 12'h055); tick();
    check("t2_trap", 64'(s_trap), 64'd1);
    check("t2_missing", 64'(s_missing), 64'b110);
    check("t2_value", 64'(s_value), 64'h000000AAA000);
    check("t3_trap", 64'(l_trap), 64'd0);
    check("t3_value", 64'(l_value), 64'h000000AAA055);

    // Context independence.
    wr(1, 0, 12'hFFF); tick();
    wr(1, 1, 12'hFFF); tick();
    wr(1, 2, 12'hFFF); tick();
    use_op(0, 3'b111, 12'h123); tick();
    check("t4_missing", 64'(s_missing), 64'b111);
    use_op(1, 3'b111, 12'h000); tick();
    check("t4_value", 64'(s_value), 64'hFFFFFFFFF000);
    check("t4_trap", 64'(s_trap), 64'd0);

    // Same-cycle use and write: no forwarding, write survives the clear.
    use_op(0, 3'b001, 12'h777); wr_en = 1; wr_bank = 0; wr_val = 12'h123; tick();
    check("t5_missing", 64'(s_missing), 64'b001);
    check("t5_bank_valid", 64'(s_bv), 64'b001);

    // Stall holds everything, then reset wins over stall.
    use_op(0, 3'b001, 12'h111); tick();
    use_op(0, 3'b111, 12'h222); stall = 1;
    for (int i = 0; i < 3; i++) tick();
    check("t6_hold_valid", 64'(s_valid), 64'd1);
    idle(); tick();
    check("t6_unstall_valid", 64'(s_valid), 64'd0);
    idle(); rst = 1; stall = 1; tick();
    check("t6_reset_value", 64'(s_value), 64'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      ctx      = 1'($urandom_range(0, 1));
      wr_en    = 1'($urandom_range(0, 1));
      wr_bank  = 2'($urandom_range(0, 3));
      wr_val   = 12'($urandom);
      use_en   = ($urandom_range(0, 2) == 0);
      use_need = 3'($urandom);
      use_low  = 12'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
